// File: rtl/dvp_camera_emitter.sv
// DVP camera-link transmitter: paces a valid/ready pixel stream into camera-style pclk/hsync/vsync/d frames.
// Frame timing (sync, porches, blanking) is generated here; the source only supplies active pixels.

module dvp_camera_emitter #(
  parameter int         ACTIVE_WIDTH   = 640,
  parameter int         ACTIVE_HEIGHT  = 480,
  parameter int         H_BLANK        = 16,
  parameter int         VSYNC_LINES    = 2,
  parameter int         V_BACK_PORCH   = 2,
  parameter int         V_FRONT_PORCH  = 2,
  parameter int         CLKS_PER_PIXEL = 2,
  parameter logic [7:0] FILL_PIXEL     = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [7:0] in_pixel_i,
  input  logic       in_valid_i,
  input  logic       in_sof_i,
  output logic       in_ready_o,
  output logic       cam_pclk_o,
  output logic       cam_hsync_o,
  output logic       cam_vsync_o,
  output logic [7:0] cam_d_o,
  output logic       frame_done_o,
  output logic       underflow_o,
  output logic       misalign_o
);

  localparam int LINE_SLOTS = ACTIVE_WIDTH + H_BLANK;
  localparam int LM_A       = (VSYNC_LINES > V_BACK_PORCH) ? VSYNC_LINES : V_BACK_PORCH;
  localparam int LM_B       = (ACTIVE_HEIGHT > V_FRONT_PORCH) ? ACTIVE_HEIGHT : V_FRONT_PORCH;
  localparam int LINE_MAX   = (LM_A > LM_B) ? LM_A : LM_B;
  localparam int PH_W       = $clog2(CLKS_PER_PIXEL);
  localparam int COL_W      = (LINE_SLOTS > 1) ? $clog2(LINE_SLOTS) : 1;
  localparam int LN_W       = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLKS_PER_PIXEL - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLKS_PER_PIXEL / 2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_SLOTS - 1);
  // One bit wider so a line with no blanking still compares correctly.
  localparam logic [COL_W:0]   ACT_LIM  = (COL_W + 1)'(ACTIVE_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFP    = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [PH_W-1:0]   ph_r, ph_s;
  logic [COL_W-1:0]  col_r, col_s;
  logic [LN_W-1:0]   line_r, line_s;
  logic              run_s, active_s, start_s, first_s, last_s;

  function automatic logic [LN_W-1:0] line_last(input state_t s);
    case (s)
      ST_VSYNC:  line_last = LN_W'(VSYNC_LINES - 1);
      ST_VBP:    line_last = LN_W'(V_BACK_PORCH - 1);
      ST_ACTIVE: line_last = LN_W'(ACTIVE_HEIGHT - 1);
      ST_VFP:    line_last = LN_W'(V_FRONT_PORCH - 1);
      default:   line_last = '0;
    endcase
  endfunction

  // First state of a new frame; zero-length sync/porch phases are skipped.
  function automatic state_t frame_start(input logic en);
    if (!en)                    frame_start = ST_IDLE;
    else if (VSYNC_LINES > 0)   frame_start = ST_VSYNC;
    else if (V_BACK_PORCH > 0)  frame_start = ST_VBP;
    else                        frame_start = ST_ACTIVE;
  endfunction

  function automatic state_t succ(input state_t s, input logic en);
    case (s)
      ST_VSYNC:  succ = (V_BACK_PORCH > 0) ? ST_VBP : ST_ACTIVE;
      ST_VBP:    succ = ST_ACTIVE;
      ST_ACTIVE: succ = (V_FRONT_PORCH > 0) ? ST_VFP : frame_start(en);
      ST_VFP:    succ = frame_start(en);
      default:   succ = ST_IDLE;
    endcase
  endfunction

  function automatic logic is_final(input state_t s);
    is_final = (s == ST_VFP) || ((s == ST_ACTIVE) && (V_FRONT_PORCH == 0));
  endfunction

  // Next-cycle counters and state; outputs are registered from these so they line up with the slot.
  always_comb begin
    state_s = state_r;
    ph_s    = ph_r;
    col_s   = col_r;
    line_s  = line_r;
    if (state_r == ST_IDLE) begin
      ph_s    = '0;
      col_s   = '0;
      line_s  = '0;
      state_s = frame_start(enable_i);
    end else if (ph_r != PH_LAST) begin
      ph_s = ph_r + 1'b1;
    end else begin
      ph_s = '0;
      if (col_r != COL_LAST) begin
        col_s = col_r + 1'b1;
      end else begin
        col_s = '0;
        if (line_r != line_last(state_r)) begin
          line_s = line_r + 1'b1;
        end else begin
          line_s  = '0;
          state_s = succ(state_r, enable_i);
        end
      end
    end
  end

  assign run_s    = (state_s != ST_IDLE);
  assign active_s = (state_s == ST_ACTIVE) && ({1'b0, col_s} < ACT_LIM);
  assign start_s  = run_s && (ph_s == '0);
  assign first_s  = active_s && (line_s == '0) && (col_s == '0);
  assign last_s   = is_final(state_s) && (line_s == line_last(state_s)) &&
                    (col_s == COL_LAST) && (ph_s == PH_LAST);

  // A pixel is taken in the cycle just before its slot opens.
  assign in_ready_o = !rst_i && active_s && start_s;

  // Timing FSM, counters and all registered link outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      ph_r         <= '0;
      col_r        <= '0;
      line_r       <= '0;
      cam_pclk_o   <= 1'b0;
      cam_hsync_o  <= 1'b0;
      cam_vsync_o  <= 1'b0;
      cam_d_o      <= 8'h00;
      frame_done_o <= 1'b0;
      underflow_o  <= 1'b0;
      misalign_o   <= 1'b0;
    end else begin
      state_r      <= state_s;
      ph_r         <= ph_s;
      col_r        <= col_s;
      line_r       <= line_s;
      cam_pclk_o   <= run_s && (ph_s >= PH_HALF);
      cam_hsync_o  <= active_s;
      cam_vsync_o  <= (state_s == ST_VSYNC);
      frame_done_o <= last_s;
      if (!active_s) begin
        cam_d_o <= 8'h00;
      end else if (start_s) begin
        cam_d_o <= in_valid_i ? in_pixel_i : FILL_PIXEL;
      end
      if (in_ready_o && !in_valid_i) begin
        underflow_o <= 1'b1;
      end
      // Start-of-frame must be present exactly on row 0 / col 0.
      if (in_ready_o && in_valid_i && (first_s != in_sof_i)) begin
        misalign_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dvp_camera_emitter.sv
// Self-checking bench for dvp_camera_emitter: expectation table for one frame, directed corner cases,
// and randomized source traffic compared every cycle against a frame-position reference model.

module tb_dvp_camera_emitter;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int HB    = 2;
  localparam int VS    = 1;
  localparam int VBP   = 1;
  localparam int VFP   = 1;
  localparam int CPP   = 2;
  localparam int LINE  = W + HB;
  localparam int LINES = VS + VBP + H + VFP;
  localparam int FRAME = LINE * LINES * CPP;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] in_pixel = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_ready, cam_pclk, cam_hsync, cam_vsync, frame_done, underflow, misalign;
  logic [7:0] cam_d;

  always #5 clk = ~clk;

  dvp_camera_emitter #(
    .ACTIVE_WIDTH(W), .ACTIVE_HEIGHT(H), .H_BLANK(HB), .VSYNC_LINES(VS),
    .V_BACK_PORCH(VBP), .V_FRONT_PORCH(VFP), .CLKS_PER_PIXEL(CPP), .FILL_PIXEL(8'h00)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .in_pixel_i(in_pixel), .in_valid_i(in_valid),
    .in_sof_i(in_sof), .in_ready_o(in_ready), .cam_pclk_o(cam_pclk), .cam_hsync_o(cam_hsync),
    .cam_vsync_o(cam_vsync), .cam_d_o(cam_d), .frame_done_o(frame_done), .underflow_o(underflow),
    .misalign_o(misalign)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference model: frame position k (0 = idle, 1..FRAME = clock within frame).
  int         mk = 0;
  logic [7:0] exp_d = 8'h00;
  logic       m_under = 1'b0;
  logic       m_mis = 1'b0;
  int         mode = 0;

  function automatic bit e_act(input int k);
    int slot, ln, col;
    if (k == 0) return 1'b0;
    slot = (k - 1) / CPP;
    ln   = slot / LINE;
    col  = slot % LINE;
    return (ln >= VS + VBP) && (ln < VS + VBP + H) && (col < W);
  endfunction

  function automatic int e_idx(input int k);
    int slot;
    slot = (k - 1) / CPP;
    return (slot / LINE - VS - VBP) * W + (slot % LINE);
  endfunction

  function automatic bit e_vs(input int k);
    return (k != 0) && (((k - 1) / CPP) / LINE < VS);
  endfunction

  function automatic bit e_pclk(input int k);
    return (k != 0) && (((k - 1) % CPP) >= CPP / 2);
  endfunction

  function automatic bit e_start(input int k);
    return (k != 0) && (((k - 1) % CPP) == 0);
  endfunction

  function automatic int next_k(input int k, input bit en, input bit r);
    if (r) return 0;
    if (k == 0 || k == FRAME) return en ? 1 : 0;
    return k + 1;
  endfunction

  // Sampled outputs of the most recent cycle and a per-frame history.
  logic       s_ready, s_pclk, s_hs, s_vs, s_fd, s_und, s_mis;
  logic [7:0] s_d;
  logic       h_ready[0:79], h_pclk[0:79], h_hs[0:79], h_vs[0:79], h_fd[0:79], h_und[0:79], h_mis[0:79];
  logic [7:0] h_d[0:79];

  // Minimal camera-reader: captures d at pclk rise while hsync is high.
  logic       prev_pclk = 1'b0;
  logic       prev_hs = 1'b0;
  int         rd_row = 0;
  int         rd_col = 0;
  logic [7:0] rd_pix[$];
  int         rd_r[$];
  int         rd_c[$];

  // Called at posedge+1: drive the source, sample at negedge, advance the model at the next edge.
  task automatic cycle();
    int         nk, idx;
    logic       er, v, s, nu, nm;
    logic [7:0] p, nd;
    nk  = next_k(mk, enable, rst);
    er  = !rst && e_act(nk) && e_start(nk);
    idx = e_act(nk) ? e_idx(nk) : -1;
    case (mode)
      0: begin v = 1'b1; p = 8'(idx + 1); s = (idx == 0); end
      1: begin v = (idx != 6); p = 8'(idx + 1); s = (idx == 0); end
      2: begin v = 1'b1; p = 8'(idx + 1); s = (idx == 0) || (idx == 3); end
      default: begin
        v = ($urandom_range(0, 6) != 0);
        p = 8'($urandom_range(0, 255));
        s = (idx == 0) ^ ($urandom_range(0, 49) == 0);
      end
    endcase
    in_valid = v;
    in_pixel = p;
    in_sof   = s;
    @(negedge clk);
    s_ready = in_ready; s_pclk = cam_pclk; s_hs = cam_hsync; s_vs = cam_vsync;
    s_d = cam_d; s_fd = frame_done; s_und = underflow; s_mis = misalign;
    check($sformatf("cycle k%0d", mk),
          32'({s_ready, s_pclk, s_hs, s_vs, s_d, s_fd, s_und, s_mis}),
          32'({er, e_pclk(mk), e_act(mk), e_vs(mk), exp_d, (mk == FRAME), m_under, m_mis}));
    if (s_vs) begin
      rd_row = 0;
      rd_col = 0;
    end else begin
      if (s_pclk && !prev_pclk && s_hs) begin
        rd_pix.push_back(s_d); rd_r.push_back(rd_row); rd_c.push_back(rd_col);
        rd_col++;
      end
      if (prev_hs && !s_hs) begin
        rd_row++;
        rd_col = 0;
      end
    end
    prev_pclk = s_pclk;
    prev_hs   = s_hs;
    nd = exp_d;
    if (e_act(nk) && e_start(nk)) nd = v ? p : 8'h00;
    else if (!e_act(nk)) nd = 8'h00;
    nu = er && !v;
    nm = er && v && ((idx == 0) != s);
    @(posedge clk);
    #1;
    if (rst) begin
      mk = 0; exp_d = 8'h00; m_under = 1'b0; m_mis = 1'b0;
    end else begin
      mk = nk; exp_d = nd; m_under = m_under | nu; m_mis = m_mis | nm;
    end
  endtask

  // One frame from idle: clk 0 is the idle cycle that first sees enable.
  task automatic run_frame(input int drop_clk);
    enable = 1'b1;
    for (int c = 0; c <= 73; c++) begin
      if (c >= drop_clk) enable = 1'b0;
      cycle();
      h_ready[c] = s_ready; h_pclk[c] = s_pclk; h_hs[c] = s_hs; h_vs[c] = s_vs;
      h_d[c] = s_d; h_fd[c] = s_fd; h_und[c] = s_und; h_mis[c] = s_mis;
    end
  endtask

  task automatic drain();
    enable = 1'b0;
    for (int i = 0; i < 2 * FRAME && mk != 0; i++) cycle();
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0;
    mk = 0; exp_d = 8'h00; m_under = 1'b0; m_mis = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    int         clk;
    logic       ready, pclk, hs, vs;
    logic [7:0] d;
    logic       fd;
  } vec_t;

  vec_t tbl[19];

  task automatic check_table();
    foreach (tbl[i]) begin
      int c;
      c = tbl[i].clk;
      check($sformatf("tbl clk%0d", c),
            32'({h_ready[c], h_pclk[c], h_hs[c], h_vs[c], h_d[c], h_fd[c], h_und[c], h_mis[c]}),
            32'({tbl[i].ready, tbl[i].pclk, tbl[i].hs, tbl[i].vs, tbl[i].d, tbl[i].fd, 1'b0, 1'b0}));
    end
  endtask

  task automatic check_reader();
    int n;
    n = rd_pix.size();
    check("rd_count", 32'(n), 32'd12);
    for (int i = 0; i < 12 && i < n; i++)
      check($sformatf("rd_px%0d", i), 32'({rd_r[i][7:0], rd_c[i][7:0], rd_pix[i]}),
            32'({8'(i / W), 8'(i % W), 8'(i + 1)}));
  endtask

  task automatic clear_reader();
    rd_pix.delete(); rd_r.delete(); rd_c.delete();
    rd_row = 0; rd_col = 0;
  endtask

  initial begin
    //         clk rdy pclk hs  vs   d     fd
    tbl[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
    tbl[1]  = '{1,  1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  1'b0};
    tbl[2]  = '{2,  1'b0, 1'b1, 1'b0, 1'b1, 8'd0,  1'b0};
    tbl[3]  = '{12, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0,  1'b0};
    tbl[4]  = '{13, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
    tbl[5]  = '{24, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0};
    tbl[6]  = '{25, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1,  1'b0};
    tbl[7]  = '{26, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1,  1'b0};
    tbl[8]  = '{27, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2,  1'b0};
    tbl[9]  = '{32, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4,  1'b0};
    tbl[10] = '{33, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
    tbl[11] = '{36, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  1'b0};
    tbl[12] = '{37, 1'b0, 1'b0, 1'b1, 1'b0, 8'd5,  1'b0};
    tbl[13] = '{50, 1'b1, 1'b1, 1'b1, 1'b0, 8'd9,  1'b0};
    tbl[14] = '{56, 1'b0, 1'b1, 1'b1, 1'b0, 8'd12, 1'b0};
    tbl[15] = '{57, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
    tbl[16] = '{71, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  1'b0};
    tbl[17] = '{72, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  1'b1};
    tbl[18] = '{73, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  1'b0};

    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    check("reset_outputs",
          32'({in_ready, cam_pclk, cam_hsync, cam_vsync, cam_d, frame_done, underflow, misalign}), 32'd0);
    cycle();
    rst = 1'b0;
    cycle();
    cycle();

    // Ramp frame against the hand-derived table, plus loopback reader.
    mode = 0;
    clear_reader();
    run_frame(1000);
    check_table();
    check_reader();
    drain();

    // Underflow on pixel index 6.
    do_reset();
    mode = 1;
    run_frame(70);
    check("uf_hs41", 32'(h_hs[41]), 32'd1);
    check("uf_d41", 32'(h_d[41]), 32'd0);
    check("uf_flag40", 32'(h_und[40]), 32'd0);
    check("uf_flag41", 32'(h_und[41]), 32'd1);
    check("uf_d43", 32'(h_d[43]), 32'd8);
    check("uf_d55", 32'(h_d[55]), 32'd12);
    check("uf_hs57", 32'(h_hs[57]), 32'd0);
    check("uf_sticky72", 32'(h_und[72]), 32'd1);
    check("uf_fd72", 32'(h_fd[72]), 32'd1);
    drain();

    // Stray sof on pixel index 3.
    do_reset();
    mode = 2;
    run_frame(70);
    check("mis_flag30", 32'(h_mis[30]), 32'd0);
    check("mis_flag31", 32'(h_mis[31]), 32'd1);
    check("mis_d31", 32'(h_d[31]), 32'd4);
    check("mis_fd72", 32'(h_fd[72]), 32'd1);
    check("mis_sticky72", 32'(h_mis[72]), 32'd1);
    check("mis_no_uf", 32'(h_und[72]), 32'd0);
    drain();

    // Enable dropped mid-frame: frame completes, then idle, then restart.
    do_reset();
    mode = 0;
    run_frame(30);
    check("en_fd71", 32'(h_fd[71]), 32'd0);
    check("en_fd72", 32'(h_fd[72]), 32'd1);
    check("en_idle_vs73", 32'(h_vs[73]), 32'd0);
    check("en_idle_pclk73", 32'(h_pclk[73]), 32'd0);
    for (int i = 0; i < 4; i++) cycle();
    check("en_idle_pclk", 32'(s_pclk), 32'd0);
    check("en_idle_ready", 32'(s_ready), 32'd0);
    enable = 1'b1;
    cycle();
    cycle();
    check("en_restart_vs", 32'(s_vs), 32'd1);
    drain();

    // Asynchronous reset in the middle of an active line.
    do_reset();
    mode = 0;
    enable = 1'b1;
    for (int c = 0; c <= 40; c++) cycle();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset",
          32'({in_ready, cam_pclk, cam_hsync, cam_vsync, cam_d, frame_done, underflow, misalign}), 32'd0);
    mk = 0; exp_d = 8'h00; m_under = 1'b0; m_mis = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    clear_reader();
    run_frame(1000);
    check_table();
    check_reader();
    drain();

    // Randomized source with random enable toggling.
    do_reset();
    mode = 3;
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
